// File: rtl/hand_judge.sv
// Hand scoring and win detection for the two-player card game.
// Optional feature macro: HAND_JUDGE_COLOR_BONUS_EN (same-colour repeat adds one extra point).
module hand_judge #(
  parameter int TARGET    = 15,
  parameter int MAX_CARDS = 5,
  parameter int SUM_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_valid,
  input  logic             player,
  input  logic [1:0]       color,
  input  logic [2:0]       number,
  input  logic             restart,
  output logic [SUM_W-1:0] sum1,
  output logic [SUM_W-1:0] sum2,
  output logic [2:0]       cnt1,
  output logic [2:0]       cnt2,
  output logic [1:0]       winner,
  output logic             finish,
  output logic             busy
);

  localparam logic [1:0] PLAY  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SUM_W-1:0] TGT = SUM_W'(TARGET);
  localparam logic [SUM_W-1:0] SAT = '1;
  localparam logic [2:0]       CAP = 3'(MAX_CARDS);

  logic [1:0] state;
  logic       owner;

  logic [SUM_W-1:0] own_sum;
  logic [2:0]       own_cnt;
  logic             accept;
  logic [SUM_W:0]   addend;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] new_sum;

  logic [SUM_W-1:0] p_sum;
  logic [1:0]       p_code;
  logic [1:0]       o_code;
  logic             both_full;
  logic             decided;
  logic [1:0]       verdict;

`ifdef HAND_JUDGE_COLOR_BONUS_EN
  logic [1:0] last_color1;
  logic [1:0] last_color2;
  logic [1:0] own_last;
  assign own_last = player ? last_color2 : last_color1;
`else
  logic unused_color;
  assign unused_color = ^color;
`endif

  assign busy = (state == CHECK);

  // Owner-side next total, widened one bit so the carry drives saturation.
  always_comb begin
    own_sum = player ? sum2 : sum1;
    own_cnt = player ? cnt2 : cnt1;
    accept  = (state == PLAY) && card_valid && (own_cnt < CAP);
    addend  = {{(SUM_W-2){1'b0}}, number};
`ifdef HAND_JUDGE_COLOR_BONUS_EN
    if (color == own_last)
      addend = addend + 1'b1;
`endif
    sum_wide = {1'b0, own_sum} + addend;
    new_sum  = sum_wide[SUM_W] ? SAT : sum_wide[SUM_W-1:0];
  end

  always_comb begin
    p_sum     = owner ? sum2 : sum1;
    p_code    = owner ? 2'b10 : 2'b01;
    o_code    = owner ? 2'b01 : 2'b10;
    both_full = (cnt1 == CAP) && (cnt2 == CAP);
    decided   = 1'b0;
    verdict   = 2'b00;
    if (p_sum == TGT) begin
      decided = 1'b1;
      verdict = p_code;
    end else if (p_sum > TGT) begin
      decided = 1'b1;
      verdict = o_code;
    end else if (both_full) begin
      decided = 1'b1;
      if (sum1 > sum2)
        verdict = 2'b01;
      else if (sum2 > sum1)
        verdict = 2'b10;
      else
        verdict = 2'b11;
    end
  end

  // Restart outranks any card arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      state  <= PLAY;
      owner  <= 1'b0;
      sum1   <= '0;
      sum2   <= '0;
      cnt1   <= '0;
      cnt2   <= '0;
      winner <= 2'b00;
      finish <= 1'b0;
`ifdef HAND_JUDGE_COLOR_BONUS_EN
      last_color1 <= 2'b00;
      last_color2 <= 2'b00;
`endif
    end else begin
      case (state)
        PLAY: begin
          finish <= 1'b0;
          if (accept) begin
            owner <= player;
            state <= CHECK;
            if (player) begin
              sum2 <= new_sum;
              cnt2 <= cnt2 + 3'd1;
            end else begin
              sum1 <= new_sum;
              cnt1 <= cnt1 + 3'd1;
            end
`ifdef HAND_JUDGE_COLOR_BONUS_EN
            if (player)
              last_color2 <= color;
            else
              last_color1 <= color;
`endif
          end
        end
        CHECK: begin
          if (decided) begin
            winner <= verdict;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            state <= PLAY;
          end
        end
        DONE: begin
          finish <= 1'b0;
        end
        default: begin
          state  <= PLAY;
          finish <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hand_judge.sv
// Self-checking bench for hand_judge: directed scenarios plus random games
// compared against a rules-level game model.
module tb_hand_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       card_valid = 1'b0;
  logic       player = 1'b0;
  logic [1:0] color = 2'd0;
  logic [2:0] number = 3'd0;
  logic       restart = 1'b0;
  logic [5:0] sum1, sum2;
  logic [2:0] cnt1, cnt2;
  logic [1:0] winner;
  logic       finish, busy;

  int n_checks = 0;
  int n_fail = 0;

  // Rules-level model of the game: hand totals, card counts, last colours, verdict.
  int m_sum[2];
  int m_cnt[2];
  int m_last[2];
  int m_win;
  bit m_over;
  bit bonus_en;

  hand_judge dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .player(player),
    .color(color), .number(number), .restart(restart),
    .sum1(sum1), .sum2(sum2), .cnt1(cnt1), .cnt2(cnt2),
    .winner(winner), .finish(finish), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
    end
    m_win = 0; m_over = 0;
  endfunction

  function automatic bit model_card(int p, int num, int col);
    int add;
    if (m_over || m_cnt[p] >= 5) return 0;
    add = num + ((bonus_en && col == m_last[p]) ? 1 : 0);
    m_sum[p] = (m_sum[p] + add > 63) ? 63 : m_sum[p] + add;
    m_cnt[p] += 1;
    m_last[p] = col;
    return 1;
  endfunction

  function automatic bit model_decide(int p);
    int o = 1 - p;
    if (m_sum[p] == 15) m_win = p + 1;
    else if (m_sum[p] > 15) m_win = o + 1;
    else if (m_cnt[0] == 5 && m_cnt[1] == 5)
      m_win = (m_sum[0] > m_sum[1]) ? 1 : (m_sum[1] > m_sum[0]) ? 2 : 3;
    else return 0;
    m_over = 1;
    return 1;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one card for one cycle; returns at the negedge after the accepting edge.
  task automatic deal(input int p, input int num, input int col, output bit acc);
    @(negedge clk);
    card_valid = 1'b1; player = p[0]; number = num[2:0]; color = col[1:0];
    @(negedge clk);
    card_valid = 1'b0;
    acc = model_card(p, num, col);
  endtask

  // Advances past the CHECK edge; optionally fires a strobe that must be dropped.
  task automatic settle(input int p, input bit acc, input bit inject, output bit dec);
    if (inject) begin
      card_valid = 1'b1; player = $urandom_range(0, 1); number = $urandom_range(1, 5);
      color = $urandom_range(1, 3);
    end
    step();
    card_valid = 1'b0;
    dec = acc ? model_decide(p) : 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    model_reset();
    n_checks += 5;
    if (sum1 !== 6'd0 || sum2 !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_sums got %0d/%0d want 0/0", sum1, sum2); end
    if (cnt1 !== 3'd0 || cnt2 !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_cnts got %0d/%0d want 0/0", cnt1, cnt2); end
    if (winner !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_winner got %b want 00", winner); end
    if (finish !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_finish got %b want 0", finish); end
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_exact_hit();
    bit acc, dec;
    do_restart();
    for (int i = 0; i < 3; i++) begin
      deal(0, 5, i + 1, acc);
      n_checks += 2;
      if (sum1 !== 6'(m_sum[0])) begin n_fail++; $display("[TB] FAIL exact_sum1 got %0d want %0d", sum1, m_sum[0]); end
      if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL exact_busy got %b want 1", busy); end
      settle(0, acc, 1'b0, dec);
      n_checks += 2;
      if (finish !== dec) begin n_fail++; $display("[TB] FAIL exact_finish got %b want %b", finish, dec); end
      if (winner !== 2'(m_win)) begin n_fail++; $display("[TB] FAIL exact_winner got %b want %0d", winner, m_win); end
    end
    step();
    n_checks += 2;
    if (finish !== 1'b0) begin n_fail++; $display("[TB] FAIL exact_finish_drop got %b want 0", finish); end
    if (winner !== 2'b01 || sum1 !== 6'd15) begin n_fail++; $display("[TB] FAIL exact_result got w=%b s=%0d want w=01 s=15", winner, sum1); end
    deal(0, 3, 2, acc);
    step();
    n_checks += 2;
    if (sum1 !== 6'd15 || cnt1 !== 3'd3) begin n_fail++; $display("[TB] FAIL done_ignore got s=%0d c=%0d want s=15 c=3", sum1, cnt1); end
    if (finish !== 1'b0 || winner !== 2'b01) begin n_fail++; $display("[TB] FAIL done_hold got f=%b w=%b want f=0 w=01", finish, winner); end
  endtask

  task automatic test_bust();
    bit acc, dec;
    int nums[4] = '{5, 5, 4, 3};
    int cols[4] = '{1, 2, 3, 1};
    do_restart();
    for (int i = 0; i < 4; i++) begin
      deal(1, nums[i], cols[i], acc);
      n_checks++;
      if (sum2 !== 6'(m_sum[1]) || cnt2 !== 3'(m_cnt[1])) begin n_fail++; $display("[TB] FAIL bust_p2 got s=%0d c=%0d want s=%0d c=%0d", sum2, cnt2, m_sum[1], m_cnt[1]); end
      settle(1, acc, 1'b0, dec);
      n_checks++;
      if (finish !== dec || winner !== 2'(m_win)) begin n_fail++; $display("[TB] FAIL bust_decide got f=%b w=%b want f=%b w=%0d", finish, winner, dec, m_win); end
    end
    n_checks++;
    if (sum2 !== 6'd17 || winner !== 2'b01) begin n_fail++; $display("[TB] FAIL bust_result got s=%0d w=%b want s=17 w=01", sum2, winner); end
  endtask

  task automatic test_full_hands(input int first_p1, input logic [1:0] want);
    bit acc, dec;
    int h1[5];
    h1 = '{first_p1, first_p1, 2, 2, 2};
    do_restart();
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 2; p++) begin
        deal(p, (p == 0) ? h1[i] : 2, ((i + p) % 3) + 1, acc);
        settle(p, acc, 1'b0, dec);
        n_checks++;
        if (finish !== dec || winner !== 2'(m_win)) begin n_fail++; $display("[TB] FAIL full_decide i=%0d p=%0d got f=%b w=%b want f=%b w=%0d", i, p, finish, winner, dec, m_win); end
      end
    end
    n_checks++;
    if (winner !== want || cnt1 !== 3'd5 || cnt2 !== 3'd5) begin n_fail++; $display("[TB] FAIL full_result got w=%b c=%0d/%0d want w=%b c=5/5", winner, cnt1, cnt2, want); end
  endtask

  task automatic test_back_to_back();
    bit acc, dec;
    do_restart();
    @(negedge clk);
    card_valid = 1'b1; player = 1'b0; number = 3'd3; color = 2'd1;
    @(negedge clk);
    acc = model_card(0, 3, 1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
    number = 3'd4; color = 2'd2;
    settle(0, acc, 1'b0, dec);
    n_checks += 2;
    if (cnt1 !== 3'd1 || sum1 !== 6'd3) begin n_fail++; $display("[TB] FAIL b2b_drop got s=%0d c=%0d want s=3 c=1", sum1, cnt1); end
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_clear got %b want 0", busy); end
  endtask

  task automatic test_sixth_card();
    bit acc, dec;
    do_restart();
    for (int i = 0; i < 5; i++) begin
      deal(0, 1, (i % 3) + 1, acc);
      settle(0, acc, 1'b0, dec);
    end
    deal(0, 4, 3, acc);
    n_checks += 2;
    if (sum1 !== 6'd5 || cnt1 !== 3'd5) begin n_fail++; $display("[TB] FAIL sixth_card got s=%0d c=%0d want s=5 c=5", sum1, cnt1); end
    if (busy !== 1'b0 || acc !== 1'b0) begin n_fail++; $display("[TB] FAIL sixth_busy got %b want 0", busy); end
  endtask

  task automatic test_restart_collision();
    bit acc, dec;
    do_restart();
    deal(0, 5, 1, acc); settle(0, acc, 1'b0, dec);
    deal(0, 5, 2, acc); settle(0, acc, 1'b0, dec);
    @(negedge clk);
    restart = 1'b1; card_valid = 1'b1; player = 1'b1; number = 3'd5; color = 2'd1;
    @(negedge clk);
    restart = 1'b0; card_valid = 1'b0;
    model_reset();
    n_checks += 2;
    if (sum1 !== 6'd0 || sum2 !== 6'd0 || cnt1 !== 3'd0 || cnt2 !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_collide got %0d/%0d %0d/%0d want all 0", sum1, sum2, cnt1, cnt2); end
    if (busy !== 1'b0 || winner !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_collide_state got b=%b w=%b want 0 00", busy, winner); end
    deal(0, 5, 1, acc); settle(0, acc, 1'b0, dec);
    deal(0, 5, 2, acc); settle(0, acc, 1'b0, dec);
    deal(0, 5, 3, acc);
    restart = 1'b1;
    step();
    restart = 1'b0;
    model_reset();
    n_checks += 2;
    if (winner !== 2'b00 || finish !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_check got w=%b f=%b want 00 0", winner, finish); end
    if (sum1 !== 6'd0 || cnt1 !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_check_regs got s=%0d c=%0d b=%b want 0 0 0", sum1, cnt1, busy); end
  endtask

  task automatic test_color_bonus();
    bit acc, dec;
    do_restart();
    deal(0, 2, 1, acc); settle(0, acc, 1'b0, dec);
    deal(0, 2, 1, acc); settle(0, acc, 1'b0, dec);
    n_checks++;
    if (sum1 !== (bonus_en ? 6'd5 : 6'd4)) begin n_fail++; $display("[TB] FAIL color_bonus got %0d want %0d", sum1, bonus_en ? 5 : 4); end
  endtask

  task automatic test_random_games();
    bit acc, dec;
    int p;
    for (int g = 0; g < 6; g++) begin
      do_restart();
      for (int k = 0; k < 14 && !m_over; k++) begin
        p = $urandom_range(0, 1);
        deal(p, $urandom_range(1, 5), $urandom_range(1, 3), acc);
        n_checks++;
        if (sum1 !== 6'(m_sum[0]) || sum2 !== 6'(m_sum[1]) || cnt1 !== 3'(m_cnt[0]) || cnt2 !== 3'(m_cnt[1]) || busy !== acc) begin
          n_fail++;
          $display("[TB] FAIL rand_regs g=%0d k=%0d got %0d/%0d %0d/%0d b=%b want %0d/%0d %0d/%0d b=%b",
                   g, k, sum1, sum2, cnt1, cnt2, busy, m_sum[0], m_sum[1], m_cnt[0], m_cnt[1], acc);
        end
        settle(p, acc, acc && ($urandom_range(0, 1) == 1), dec);
        n_checks++;
        if (finish !== dec || winner !== 2'(m_win)) begin n_fail++; $display("[TB] FAIL rand_decide g=%0d k=%0d got f=%b w=%b want f=%b w=%0d", g, k, finish, winner, dec, m_win); end
        if ($urandom_range(0, 1) == 1) step();
      end
    end
  endtask

  initial begin
`ifdef HAND_JUDGE_COLOR_BONUS_EN
    bonus_en = 1'b1;
`else
    bonus_en = 1'b0;
`endif
    model_reset();
    test_reset();
    test_exact_hit();
    test_bust();
    test_full_hands(3, 2'b01);
    test_full_hands(2, 2'b11);
    test_back_to_back();
    test_sixth_card();
    test_restart_collision();
    test_color_bonus();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hand_judge.md
# hand_judge

Scoring and win-detection stage for the two-player card game. It consumes each dealt card (colour, number, owning player) from the card-value and demux path, accumulates per-player hand totals and card counts, and decides the game outcome. It emits a one-cycle `finish` pulse that the draw counter uses to clear itself.

## Interface

Parameters:
- `TARGET`, default 15: exact-hit winning total.
- `MAX_CARDS`, default 5: hand capacity per player.
- `SUM_W`, default 6: width of the hand-total registers.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `card_valid`  in  1  one-cycle strobe; a card is presented this cycle.
- `player`  in  1  card owner: 0 = player 1, 1 = player 2.
- `color`  in  2  card colour, 1..3.
- `number`  in  3  card value, 1..5.
- `restart`  in  1  clears the game; level-sampled each cycle.
- `sum1`, `sum2`  out  SUM_W  registered hand totals.
- `cnt1`, `cnt2`  out  3  registered cards held per player.
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- `finish`  out  1  one-cycle pulse when the game is decided.
- `busy`  out  1  high in CHECK; cards are dropped while high.

## Operation

- FSM states: PLAY, CHECK, DONE. Reset state is PLAY.
- Reset values: sums 0, counts 0, `winner` 00, `finish` 0, `busy` 0.
- Card acceptance:
  - A card is accepted only in PLAY with `card_valid`=1 and the owning hand's count < MAX_CARDS.
  - On acceptance: the owner's sum += `number` (zero-extended), the owner's count += 1, owner index latched, state → CHECK.
  - A card to a full hand is ignored: no register change, state stays PLAY.
- Sum arithmetic: unsigned, saturating at 2^SUM_W−1. No wrap.
- CHECK lasts exactly one cycle. Let P be the latched owner and O the other player.
  - sumP == TARGET → `winner` = P, go to DONE.
  - else sumP > TARGET → `winner` = O (bust), go to DONE.
  - else both counts == MAX_CARDS → the larger sum wins; equal sums → `winner` = 11; go to DONE.
  - else return to PLAY.
- `finish` is high for exactly the one cycle following the CHECK→DONE transition.
- DONE: all `card_valid` is ignored; `winner` and the sums hold.
- `restart`=1 in any state (including mid-CHECK): next edge clears sums, counts and `winner`, deasserts `finish`, and enters PLAY.
  - `restart` has priority over `card_valid` in the same cycle; that card is dropped.
- `card_valid` during CHECK is dropped, not queued.

## Timing

- Card at edge k: sum and count are visible after edge k.
- Decision made at edge k+1; `winner` and `finish` are visible after edge k+1.
- `finish` drops after edge k+2.
- Back-to-back cards: at most one accepted every 2 cycles. The second strobe of an adjacent pair is lost and `busy` flags it.
- `restart` latency is 1 edge.

## Configuration

- `HAND_JUDGE_COLOR_BONUS_EN` defined:
  - A per-player last-colour register is kept, reset to 00 and cleared by `restart`.
  - An accepted card whose `color` equals the owner's previous card colour adds `number`+1 instead of `number`.
  - The bonus is applied before saturation.
- Not defined: no colour registers; a card adds exactly `number`.

## Test plan

- Reset held 2 cycles, then released → sums 0, counts 0, `winner` 00, `finish` 0, `busy` 0.
- Player 1 is dealt 5,5,5 with cards ≥2 cycles apart → after the third card `sum1`=15, `finish` high 1 cycle, `winner`=01; a further card is ignored.
- Player 2 is dealt 5,5,4,3 → `sum2`=17 (bust) → `winner`=01, `finish` pulse.
- Both players fill 5 cards:
  - Player 1 {3,3,2,2,2}=12 vs player 2 {2,2,2,2,2}=10 → `winner`=01.
  - Rerun with player 1 at 10 → `winner`=11.
- Hazard cases:
  - `card_valid` on consecutive cycles → second card dropped, count +1 only.
  - Sixth card to a full hand → no change.
  - `restart` and `card_valid` in the same cycle → all cleared, card dropped, state PLAY.
- Colour bonus:
  - With `HAND_JUDGE_COLOR_BONUS_EN`: player 1 gets (color 01, 2) then (color 01, 2) → `sum1`=5.
  - Without the macro, the same stimulus → `sum1`=4.
